// File: rtl/mega_and_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational mega_and unit among N_REQ requesters.
// Optional: define MEGA_AND_ARB_ZERO_FLAG_EN to add the registered RSP_ZERO output.
module mega_and_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 64,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N_REQ-1:0]       REQ_VALID,
    output logic [N_REQ-1:0]       REQ_READY,
    input  logic [N_REQ*WIDTH-1:0] REQ_A,
    input  logic [N_REQ*WIDTH-1:0] REQ_B,
    output logic [WIDTH-1:0]       AND_A,
    output logic [WIDTH-1:0]       AND_B,
    input  logic [WIDTH-1:0]       AND_R,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [ID_W-1:0]        RSP_ID,
`ifdef MEGA_AND_ARB_ZERO_FLAG_EN
    output logic                   RSP_ZERO,
`endif
    output logic [WIDTH-1:0]       RSP_R
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  a_q, b_q, r_q;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  sel_a, sel_b;

    // First valid requester at or above ptr, wrapping past N_REQ-1.
    always_comb begin
        logic [ID_W:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!gnt_found && REQ_VALID[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[ID_W-1:0];
            end
        end
    end

    assign sel_a = REQ_A[gnt_idx*WIDTH +: WIDTH];
    assign sel_b = REQ_B[gnt_idx*WIDTH +: WIDTH];

    // RST_N gates the grant so nothing is accepted while reset is held.
    always_comb begin
        REQ_READY = '0;
        if (state_q == IDLE && gnt_found && RST_N)
            REQ_READY[gnt_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= '0;
            r_q   <= '0;
            ptr_q <= '0;
        end else begin
            if (state_q == IDLE && gnt_found) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= gnt_idx;
            end
            if (state_q == EXEC)
                r_q <= AND_R;
            if (state_q == RESP && RSP_READY)
                ptr_q <= (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
        end
    end

`ifdef MEGA_AND_ARB_ZERO_FLAG_EN
    logic zero_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                zero_q <= 1'b0;
        else if (state_q == EXEC)  zero_q <= (AND_R == '0);
    end
    assign RSP_ZERO = zero_q;
`endif

    assign AND_A     = a_q;
    assign AND_B     = b_q;
    assign RSP_R     = r_q;
    assign RSP_ID    = id_q;
    assign RSP_VALID = (state_q == RESP);

endmodule

// File: tb/tb_mega_and_arbiter.sv
// Bench for mega_and_arbiter: directed stimulus, a cycle-level behavioural model checked every cycle.
module tb_mega_and_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [W-1:0]     and_a, and_b, and_r;
    logic             rsp_valid, rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_r;
    logic             rsp_zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The attached shared unit.
    assign and_r = and_a & and_b;

    mega_and_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_B(req_b),
        .AND_A(and_a), .AND_B(and_b), .AND_R(and_r),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_ID(rsp_id),
`ifdef MEGA_AND_ARB_ZERO_FLAG_EN
        .RSP_ZERO(rsp_zero),
`endif
        .RSP_R(rsp_r)
    );
`ifndef MEGA_AND_ARB_ZERO_FLAG_EN
    assign rsp_zero = 1'b0;
`endif

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Model: m_age = cycles since accepted handshake (-1 when nothing in flight).
    int           m_age = -1, m_ptr = 0, m_id = 0;
    logic [W-1:0] m_a = '0, m_b = '0;

    // Observations of the DUT for directed literal checks.
    int           log_id[$], log_lat[$];
    logic [W-1:0] log_r[$];
    logic         log_z[$];
    int           gnt_cnt = 0, gnt_last = -1, hs_cyc = 0, lat = 0;
    logic         prev_vld = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_age = -1; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0;
            prev_vld = 1'b0;
            chk("rst_req_ready", W'(req_ready), '0);
            chk("rst_rsp_valid", W'(rsp_valid), '0);
            chk("rst_and_a", and_a, '0);
            chk("rst_and_b", and_b, '0);
            chk("rst_rsp_r", rsp_r, '0);
            chk("rst_rsp_id", W'(rsp_id), '0);
            chk("rst_rsp_zero", W'(rsp_zero), '0);
        end else begin
            logic [N-1:0] exp_ready;
            int g;
            exp_ready = '0;
            g = -1;
            if (m_age < 0 && |req_valid) begin
                g = rr_pick(m_ptr, req_valid);
                exp_ready[g] = 1'b1;
            end
            chk("req_ready", W'(req_ready), W'(exp_ready));
            chk("rsp_valid", W'(rsp_valid), W'(m_age >= 2));
            chk("and_a", and_a, m_a);
            chk("and_b", and_b, m_b);
            if (m_age >= 2) begin
                chk("rsp_id", W'(rsp_id), W'(m_id));
                chk("rsp_r", rsp_r, m_a & m_b);
`ifdef MEGA_AND_ARB_ZERO_FLAG_EN
                chk("rsp_zero", W'(rsp_zero), W'((m_a & m_b) == '0));
`endif
            end
            // DUT observation log
            if (|(req_ready & req_valid)) begin
                hs_cyc = cyc;
                gnt_cnt++;
                for (int i = 0; i < N; i++) if (req_ready[i]) gnt_last = i;
            end
            if (rsp_valid && !prev_vld) lat = cyc - hs_cyc;
            if (rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_r.push_back(rsp_r);
                log_z.push_back(rsp_zero);
                log_lat.push_back(lat);
            end
            prev_vld = rsp_valid;
            // model advance
            if (m_age < 0) begin
                if (g >= 0) begin
                    m_id = g; m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W]; m_age = 1;
                end
            end else if (m_age < 2) begin
                m_age++;
            end else if (rsp_ready) begin
                m_ptr = (m_id + 1) % N;
                m_age = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_gnt(input int n);
        int c = 0;
        while (gnt_cnt < n && c < 50) begin tick(); c++; end
        tests++;
        if (gnt_cnt < n) begin
            fails++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", gnt_cnt, n);
        end
    endtask

    task automatic wait_rsp(input int n);
        int c = 0;
        while (log_id.size() < n && c < 100) begin tick(); c++; end
        tests++;
        if (log_id.size() < n) begin
            fails++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", log_id.size(), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, g0;
        logic [W-1:0] v;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #1;
        req_valid = '1;
        repeat (3) tick();
        chk("reset_ready_literal", W'(req_ready), '0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Round robin, all valid continuously.
        for (int i = 0; i < N; i++) set_req(i, '1, W'(i + 1));
        base = log_id.size();
        req_valid = '1;
        wait_rsp(base + 5);
        req_valid = '0;
        if (log_id.size() >= base + 5)
            for (int k = 0; k < 5; k++) begin
                chk("rr_id", W'(log_id[base+k]), W'(k % 4));
                chk("rr_r", log_r[base+k], W'(k % 4 + 1));
            end
        tick();

        // Single op from requester 0.
        set_req(0, '1, 64'hAAAA_AAAA_AAAA_AAAA);
        base = log_id.size(); g0 = gnt_cnt;
        req_valid = 4'b0001;
        wait_gnt(g0 + 1);
        req_valid = '0;
        wait_rsp(base + 1);
        if (log_id.size() > base) begin
            chk("single_id", W'(log_id[base]), '0);
            chk("single_r", log_r[base], 64'hAAAA_AAAA_AAAA_AAAA);
            chk("single_latency", W'(log_lat[base]), W'(2));
        end

        // Backpressure: requester 1 held in RESP while requester 2 waits.
        set_req(1, 64'hFF00_FF00_1234_5678, 64'h0F0F_F0F0_FFFF_0000);
        set_req(2, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0030);
        rsp_ready = 1'b0;
        base = log_id.size(); g0 = gnt_cnt;
        req_valid = 4'b0110;
        wait_gnt(g0 + 1);
        req_valid = 4'b0100;
        begin
            int c = 0;
            while (!rsp_valid && c < 10) begin tick(); c++; end
        end
        repeat (10) begin
            tick();
            chk("bp_req_ready", W'(req_ready), '0);
            chk("bp_rsp_valid", W'(rsp_valid), W'(1));
            chk("bp_rsp_id", W'(rsp_id), W'(1));
            chk("bp_rsp_r", rsp_r, 64'h0F00_F000_1234_0000);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_count", W'(log_id.size()), W'(base + 1));
        wait_gnt(g0 + 2);
        req_valid = '0;
        wait_rsp(base + 2);
        if (log_id.size() >= base + 2) begin
            chk("bp_id", W'(log_id[base]), W'(1));
            chk("bp_next_id", W'(log_id[base+1]), W'(2));
            chk("bp_next_r", log_r[base+1], W'(64'h30));
        end

        // Pointer wrap: grant 3, then only 0 and 2 valid.
        for (int i = 0; i < N; i++) set_req(i, W'(i + 16), '1);
        base = log_id.size(); g0 = gnt_cnt;
        req_valid = 4'b1000;
        wait_gnt(g0 + 1);
        req_valid = '0;
        wait_rsp(base + 1);
        req_valid = 4'b0101;
        wait_gnt(g0 + 2);
        chk("wrap_first_grant", W'(gnt_last), '0);
        req_valid = 4'b0100;
        wait_gnt(g0 + 3);
        req_valid = '0;
        wait_rsp(base + 3);
        if (log_id.size() >= base + 3) begin
            chk("wrap_id0", W'(log_id[base+1]), '0);
            chk("wrap_id2", W'(log_id[base+2]), W'(2));
        end

        // Reset during EXEC.
        set_req(1, 64'h55, 64'h77);
        g0 = gnt_cnt;
        req_valid = 4'b0010;
        wait_gnt(g0 + 1);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", W'(rsp_valid), '0);
        chk("midrst_and_a", and_a, '0);
        chk("midrst_and_b", and_b, '0);
        chk("midrst_rsp_r", rsp_r, '0);
        chk("midrst_ready", W'(req_ready), '0);
        repeat (2) tick();
        rst_n = 1'b1;
        base = log_id.size(); g0 = gnt_cnt;
        set_req(0, 64'h3, 64'h6);
        set_req(3, 64'hF, 64'hF);
        req_valid = 4'b1001;
        wait_gnt(g0 + 1);
        chk("postrst_grant", W'(gnt_last), '0);
        req_valid = '0;
        wait_rsp(base + 1);
        repeat (4) tick();
        chk("postrst_no_stale", W'(log_id.size()), W'(base + 1));
        if (log_id.size() > base) chk("postrst_r", log_r[base], W'(2));

        // Sweep A=0..9, B=A+2.
        for (int i = 0; i < 10; i++) begin
            set_req(i % N, W'(i), W'(i + 2));
            base = log_id.size(); g0 = gnt_cnt;
            req_valid = '0;
            req_valid[i % N] = 1'b1;
            wait_gnt(g0 + 1);
            req_valid = '0;
            wait_rsp(base + 1);
            v = W'(i & (i + 2));
            if (log_id.size() > base) begin
                chk("sweep_r", log_r[base], v);
`ifdef MEGA_AND_ARB_ZERO_FLAG_EN
                chk("sweep_zero", W'(log_z[base]), W'(v == '0));
`endif
            end
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mega_and_arbiter.md
# mega_and_arbiter

Round-robin arbiter and sequencer that shares one combinational `mega_and` 64-bit AND unit among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared unit from registered operands. It captures the result and returns it, tagged with the requester ID, over a single valid/ready response channel. It sits between the requester ports and the single `mega_and` instance, which connects through the `AND_*` ports.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 64: operand/result width; must match the attached `mega_and`.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `REQ_VALID` in N_REQ: bit i set when requester i offers operands.
- `REQ_READY` out N_REQ: one-hot grant/accept; at most one bit set.
- `REQ_A` in N_REQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `REQ_B` in N_REQ*WIDTH: operand B; same packing as `REQ_A`.
- `AND_A` out WIDTH: operand A to the shared `mega_and`, registered.
- `AND_B` out WIDTH: operand B to the shared `mega_and`, registered.
- `AND_R` in WIDTH: result from the shared `mega_and` (combinational, same cycle).
- `RSP_VALID` out 1: response available.
- `RSP_READY` in 1: consumer accepts the response.
- `RSP_ID` out clog2(N_REQ): index of the requester that owns the response.
- `RSP_R` out WIDTH: registered result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `REQ_VALID` bit is set, grant the first set bit at or after round-robin pointer `ptr`, searching upward with wrap from `N_REQ-1` to 0.
  - `REQ_READY[g]` is asserted combinationally in this cycle only.
  - On the edge, latch `REQ_A[g]` into `AND_A`, `REQ_B[g]` into `AND_B`, and g into the ID register, then go to EXEC.
  - If no `REQ_VALID` bit is set, stay in IDLE.
- EXEC: on the edge, latch `AND_R` into `RSP_R`, set `RSP_VALID`, go to RESP.
- RESP:
  - Hold `RSP_VALID`, `RSP_ID` and `RSP_R` stable until `RSP_READY` is seen.
  - On `RSP_VALID && RSP_READY`, clear `RSP_VALID`, set `ptr` to (g+1) mod `N_REQ`, and return to IDLE.
- `REQ_READY` is all-zero in EXEC and RESP. New requests wait; they are not dropped.
- A requester may deassert `REQ_VALID` before it is granted; no state changes as a result.
- `AND_A`/`AND_B` keep their value after the operation; they change only on the next grant.
- Reset: asynchronous assertion forces state IDLE and `ptr`=0. `AND_A`, `AND_B`, `RSP_R`, `RSP_ID`, `RSP_VALID` and the optional `RSP_ZERO` all go to 0. `REQ_READY` is 0 while `RST_N` is low. Any in-flight operation or pending response is discarded, not replayed.

## Timing
- Request handshake in cycle T, then `RSP_VALID` high from cycle T+2.
- Minimum issue interval is 3 cycles per operation, with `RSP_READY` tied high.
- Back-to-back issue: a RESP handshake in cycle U allows the next grant in cycle U+1.
- With `RSP_READY` stuck low, the block stalls indefinitely in RESP. No timeout.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than `N_REQ-1` other operations.

## Configuration
- `MEGA_AND_ARB_ZERO_FLAG_EN` defined:
  - Adds output `RSP_ZERO` (1 bit), registered in EXEC alongside `RSP_R`.
  - It is 1 when `AND_R` is all-zero and holds with `RSP_R`. Reset value 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Single op: requester 0 with A=all-ones, B=0xAAAAAAAAAAAAAAAA → `RSP_R`=0xAAAAAAAAAAAAAAAA, `RSP_ID`=0, `RSP_VALID` exactly 2 cycles after the handshake.
- Round-robin: all 4 requesters valid continuously, each with A=-1 and B=requester index+1, `RSP_READY`=1 → responses in ID order 0,1,2,3,0 with `RSP_R`=1,2,3,4,1.
- Backpressure: hold `RSP_READY`=0 for 10 cycles during RESP → `RSP_R`/`RSP_ID` stable, `REQ_READY`=0 throughout, completes on the first cycle `RSP_READY`=1.
- Pointer wrap: after a grant to requester 3, only requesters 0 and 2 valid → next grant 0, then 2.
- Reset mid-op: deassert `RST_N` in EXEC → all outputs 0 immediately. After release, the first grant goes to requester 0 and no stale response appears.
- Sweep: A=0..9 × B=2..11 against the behavioural A&B → every `RSP_R` matches. With `MEGA_AND_ARB_ZERO_FLAG_EN` defined, `RSP_ZERO`=1 exactly when A&B=0 (e.g. A=1, B=2).
